// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types and constants for the transmitter and receiver
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

    localparam int UART_CLKS_PER_BIT_DEFAULT = 434;
    localparam int UART_DATA_BITS            = 8;

endpackage

// File: rtl/uart_baud_gen.sv
// rtl/uart_baud_gen.sv - bit-period counter producing a tick on the last cycle of each bit
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic en,
    output logic tick
);

    localparam int              CW   = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0]   LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] count;

    // Saturates at LAST; the owner clears it on the bit boundary.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (en && (count != LAST)) begin
            count <= count + CW'(1);
        end
    end

    assign tick = en && (count == LAST);

endmodule

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - 8N1 LSB-first UART transmitter with valid/ready byte input
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data,
    input  logic       data_valid,
    output logic       ready,
    output logic       tx,
    output logic       busy
);

    localparam logic [2:0] LAST_BIT = 3'(UART_DATA_BITS - 1);

    uart_state_t state;
    logic [7:0]  shift_reg;
    logic [2:0]  bit_idx;
    logic        accept;
    logic        tick;

    assign accept = data_valid && ready;
    assign busy   = ~ready;

    uart_baud_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk  (clk),
        .rst  (rst),
        .clear(accept || tick),
        .en   (state != IDLE),
        .tick (tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            tx        <= 1'b1;
            ready     <= 1'b1;
            shift_reg <= 8'h00;
            bit_idx   <= 3'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        shift_reg <= data;
                        bit_idx   <= 3'd0;
                        tx        <= 1'b0;
                        ready     <= 1'b0;
                        state     <= START;
                    end
                end
                START: begin
                    if (tick) begin
                        tx    <= shift_reg[0];
                        state <= DATA;
                    end
                end
                DATA: begin
                    if (tick) begin
                        shift_reg <= {1'b0, shift_reg[7:1]};
                        if (bit_idx == LAST_BIT) begin
                            bit_idx <= 3'd0;
                            tx      <= 1'b1;
                            state   <= STOP;
                        end else begin
                            // Next bit is the one about to land in shift_reg[0].
                            bit_idx <= bit_idx + 3'd1;
                            tx      <= shift_reg[1];
                        end
                    end
                end
                STOP: begin
                    if (tick) begin
                        ready <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: begin
                    tx    <= 1'b1;
                    ready <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/uart_tx.md
# uart_tx

Serial UART transmitter, 8N1, LSB first, paired with the existing receiver on the same link. It accepts one byte per valid/ready handshake from the calculator datapath and shifts it out on `tx` at a fixed baud rate derived from `clk`. Sits at the chip boundary, driving the host serial line.

## Interface
- `CLKS_PER_BIT`, default 434, clock cycles per serial bit (50 MHz / 115200); legal range 2..65535.
- `clk`  input  1  system clock; all logic on rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `data`  input  8  byte to transmit; sampled only on accept.
- `data_valid`  input  1  `data` holds a byte for transmission.
- `ready`  output  1  transmitter can accept a byte this cycle.
- `tx`  output  1  serial line; idle high.
- `busy`  output  1  frame in progress; the inverse of `ready`.

## Operation
- Accept: `data_valid && ready` at a rising edge. `data` is latched into an 8-bit shift register. The FSM leaves IDLE.
- `data_valid` without `ready` is ignored. No byte is queued, and the source must hold `data`/`data_valid`.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: `tx`=1, `ready`=1. On accept, go to START.
  - START: `tx`=0 for `CLKS_PER_BIT` cycles, then go to DATA.
  - DATA: `tx`=shift_reg[0] for `CLKS_PER_BIT` cycles per bit. Shift right at each bit end. After 8 bits, go to STOP.
  - STOP: `tx`=1 for `CLKS_PER_BIT` cycles, then go to IDLE.
- Baud counter: width `$clog2(CLKS_PER_BIT)`. Cleared on accept and on every bit boundary. Counts 0..`CLKS_PER_BIT`-1. The bit-end tick is count==`CLKS_PER_BIT`-1. No wrap beyond that value.
- Bit index: 3-bit counter, 0..7, used in DATA only. DATA exits on the tick with index==7.
- `ready` = (state==IDLE), registered with the state. `busy` = ~`ready`.
- `tx` is a registered output with no combinational path from inputs.
- Reset mid-frame: the frame is aborted and the next cycle is IDLE with `tx`=1. A truncated frame on the line is acceptable.
- Reset values: state IDLE, `tx`=1, `ready`=1, `busy`=0, shift register 0x00, counters 0.
- Changes to `data` while busy have no effect on the frame in flight.

## Timing
- Accept at edge N: `tx` falls at edge N+1. The start bit occupies cycles N+1 .. N+`CLKS_PER_BIT`.
- Data bit k (0..7) starts at edge N+1+(k+1)·`CLKS_PER_BIT`.
- Stop bit starts at N+1+9·`CLKS_PER_BIT`. `ready` rises at N+1+10·`CLKS_PER_BIT`.
- Back-to-back frames: with `data_valid` held high, the next accept happens on the first IDLE cycle. The frame period is 10·`CLKS_PER_BIT`+1 cycles, and the line stays high one extra cycle between frames.
- `ready` falls the cycle after accept.
- `rst` asserted for one cycle is sufficient and takes effect at that edge.

## Structure
- Shared package `uart_pkg`:
  - FSM state typedef (IDLE=2'd0, START=2'd1, DATA=2'd2, STOP=2'd3), also used by the receiver.
  - `UART_CLKS_PER_BIT_DEFAULT`=434.
  - `UART_DATA_BITS`=8.
- Sub-module `uart_baud_gen`: counter with `clear` and `en` inputs and a `tick` output, parameterised by `CLKS_PER_BIT`. The receiver is to be refactored to reuse it.
- Top `uart_tx`: FSM, shift register, bit index, output registers.

## Test plan
All scenarios use `CLKS_PER_BIT`=4 unless stated.
- Reset: hold `rst` 2 cycles → `tx`=1, `ready`=1, `busy`=0. No toggling for 50 cycles with `data_valid`=0.
- Single byte 0xA5, accepted at edge N → `tx` reads 0,1,0,1,0,0,1,0,1,1, each level held exactly 4 cycles starting at N+1. `ready`=0 from N+1 through N+40 and 1 at N+41.
- Back-to-back 0x00 then 0xFF with `data_valid` held → second start bit falls at N+42. `tx` high exactly 5 cycles between frames (stop bit plus 1 idle). Payloads are correct.
- `data` changed from 0x3C to 0xC3 mid-frame, `data_valid` low → 0x3C transmitted. No second frame.
- `rst` pulsed during data bit 3 of 0x55 → `tx`=1 and `ready`=1 on the next cycle. A new accept of 0x81 then produces a clean full frame.
- `CLKS_PER_BIT`=434, byte 0x0D → each bit 434 cycles, frame 4340 cycles. A loopback into the receiver recovers 0x0D.
